// File: rtl/spi_multi_slave_select.sv
// spi_multi_slave_select: drives one of NUM_SS active-low selects low for BaudRateDivisor_i*(frame_len_i+1) PCLK cycles.
// Latency: registered outputs; ss_o/tip_o change one PCLK after the accepted request edge.
// Backpressure: none. Requests outside a legal IDLE sample are dropped (1-deep hold in GUARD with SPI_SS_GUARD_EN).
module spi_multi_slave_select #(
  parameter int NUM_SS    = 4,
  parameter int SEL_W     = 2,
  parameter int BAUD_W    = 12,
  parameter int LEN_W     = 5,
  parameter int GUARD_CYC = 4
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              mstr_i,
  input  logic              spiswai_i,
  input  logic [1:0]        spi_mode_i,
  input  logic              send_data_i,
  input  logic [BAUD_W-1:0] BaudRateDivisor_i,
  input  logic [LEN_W-1:0]  frame_len_i,
  input  logic [SEL_W-1:0]  ss_sel_i,
  output logic [NUM_SS-1:0] ss_o,
  output logic              tip_o,
  output logic              recieve_data_o
);

  // Product of divisor and bit count never overflows this width.
  localparam int TGT_W = BAUD_W + LEN_W;
  localparam logic [SEL_W:0]     SEL_LIM = (SEL_W+1)'(NUM_SS);
  localparam logic [NUM_SS-1:0]  SS_IDLE = '1;
  localparam logic [NUM_SS-1:0]  SS_ONE  = NUM_SS'(1);

`ifdef SPI_SS_GUARD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2, GUARD = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [TGT_W-1:0]  target_q, target_d;
  logic [TGT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_SS-1:0] ss_q, ss_d;
  logic              tip_q, tip_d;
  logic              rcv_q, rcv_d;
  logic              active;
  logic              start_ok;
  logic              req;
`ifdef SPI_SS_GUARD_EN
  logic              pend_q, pend_d;
`endif

  // Block qualification: master mode, and either run mode or wait mode without stop-in-wait.
  always_comb begin
    active   = 1'b0;
    start_ok = 1'b0;
    active   = mstr_i & ((spi_mode_i == 2'b00) | ((spi_mode_i == 2'b01) & ~spiswai_i));
    start_ok = active & (BaudRateDivisor_i != '0) & ({1'b0, ss_sel_i} < SEL_LIM);
  end

  // Next-state and registered-output computation; the counter doubles as the guard timer.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    ss_d     = SS_IDLE;
    tip_d    = 1'b0;
    rcv_d    = 1'b0;
    req      = send_data_i;
`ifdef SPI_SS_GUARD_EN
    pend_d   = pend_q;
    req      = send_data_i | pend_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
`ifdef SPI_SS_GUARD_EN
        // A held request is either consumed here or dropped as illegal.
        pend_d = 1'b0;
`endif
        if (req && start_ok) begin
          state_d  = XFER;
          sel_d    = ss_sel_i;
          target_d = TGT_W'(BaudRateDivisor_i) * (TGT_W'(frame_len_i) + TGT_W'(1));
          ss_d     = ~(SS_ONE << ss_sel_i);
          tip_d    = 1'b1;
        end
      end
      XFER: begin
        if (!active) begin
          // Abort: drop the frame silently.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == target_q - TGT_W'(1)) begin
          state_d = DONE;
          cnt_d   = '0;
          rcv_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + TGT_W'(1);
          ss_d  = ~(SS_ONE << sel_q);
          tip_d = 1'b1;
        end
      end
      DONE: begin
        cnt_d = '0;
`ifdef SPI_SS_GUARD_EN
        state_d = GUARD;
`else
        state_d = IDLE;
`endif
      end
`ifdef SPI_SS_GUARD_EN
      GUARD: begin
        if (send_data_i) pend_d = 1'b1;
        if (cnt_q == TGT_W'(GUARD_CYC - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TGT_W'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
`ifdef SPI_SS_GUARD_EN
    if (!active) pend_d = 1'b0;
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      ss_q     <= SS_IDLE;
      tip_q    <= 1'b0;
      rcv_q    <= 1'b0;
`ifdef SPI_SS_GUARD_EN
      pend_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      ss_q     <= ss_d;
      tip_q    <= tip_d;
      rcv_q    <= rcv_d;
`ifdef SPI_SS_GUARD_EN
      pend_q   <= pend_d;
`endif
    end
  end

  assign ss_o           = ss_q;
  assign tip_o          = tip_q;
  assign recieve_data_o = rcv_q;

endmodule

// File: tb/tb_spi_multi_slave_select.sv
// tb_spi_multi_slave_select: randomized and directed frames against an arithmetic model of
// frame length, selected line, in-progress flag and completion pulse.
// Inputs driven on falling edges; outputs sampled on falling edges.
module tb_spi_multi_slave_select;

  localparam int NUM_SS    = 4;
  localparam int SEL_W     = 2;
  localparam int BAUD_W    = 12;
  localparam int LEN_W     = 5;
  localparam int GUARD_CYC = 4;
`ifdef SPI_SS_GUARD_EN
  localparam int GAP = 2 + GUARD_CYC;
`else
  localparam int GAP = 2;
`endif
  localparam logic [NUM_SS-1:0] ALL1 = '1;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              mstr_i;
  logic              spiswai_i;
  logic [1:0]        spi_mode_i;
  logic              send_data_i;
  logic [BAUD_W-1:0] BaudRateDivisor_i;
  logic [LEN_W-1:0]  frame_len_i;
  logic [SEL_W-1:0]  ss_sel_i;
  logic [NUM_SS-1:0] ss_o;
  logic              tip_o;
  logic              recieve_data_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  spi_multi_slave_select #(
    .NUM_SS(NUM_SS), .SEL_W(SEL_W), .BAUD_W(BAUD_W), .LEN_W(LEN_W), .GUARD_CYC(GUARD_CYC)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .mstr_i(mstr_i), .spiswai_i(spiswai_i),
    .spi_mode_i(spi_mode_i), .send_data_i(send_data_i),
    .BaudRateDivisor_i(BaudRateDivisor_i), .frame_len_i(frame_len_i), .ss_sel_i(ss_sel_i),
    .ss_o(ss_o), .tip_o(tip_o), .recieve_data_o(recieve_data_o)
  );

  always #5 PCLK = ~PCLK;

  // Reference model: frame length in PCLK cycles (0 = request refused).
  function automatic int model_len(input bit mstr, input bit wai, input int mode,
                                   input int div, input int len, input int sel);
    bit act;
    act = mstr && (mode == 0 || (mode == 1 && !wai));
    if (!act || div == 0 || sel >= NUM_SS) return 0;
    return div * (len + 1);
  endfunction

  function automatic logic [NUM_SS-1:0] model_line(input int sel);
    logic [NUM_SS-1:0] m;
    m = '1;
    m[sel] = 1'b0;
    return m;
  endfunction

  task automatic drive(input bit mstr, input bit wai, input int mode,
                       input int div, input int len, input int sel);
    mstr_i            = mstr;
    spiswai_i         = wai;
    spi_mode_i        = 2'(mode);
    BaudRateDivisor_i = BAUD_W'(div);
    frame_len_i       = LEN_W'(len);
    ss_sel_i          = SEL_W'(sel);
  endtask

  task automatic pulse();
    @(negedge PCLK);
    send_data_i = 1'b1;
    @(negedge PCLK);
    send_data_i = 1'b0;
  endtask

  // Measures one frame window; returns at the first all-high sample (or when the budget runs out).
  task automatic observe(input int budget, output int low_n, output logic [NUM_SS-1:0] line,
                         output int tip_n, output int rcv_in, output logic rcv_end,
                         output logic tip_end);
    int k;
    k = 0; low_n = 0; tip_n = 0; rcv_in = 0;
    line = ss_o;
    while (ss_o !== ALL1 && k < budget) begin
      k++;
      if (ss_o === line) low_n++;
      if (tip_o === 1'b1) tip_n++;
      if (recieve_data_o === 1'b1) rcv_in++;
      @(negedge PCLK);
    end
    rcv_end = recieve_data_o;
    tip_end = tip_o;
  endtask

  task automatic idle_wait();
    repeat (GUARD_CYC + 4) @(negedge PCLK);
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    send_data_i = 1'b0;
    drive(1, 0, 0, 2, 7, 1);
    repeat (3) @(negedge PCLK);
    vec_cnt++; if (ss_o !== ALL1) begin err_cnt++; $display("FAIL reset_ss: got %b want %b", ss_o, ALL1); end
    vec_cnt++; if (tip_o !== 1'b0) begin err_cnt++; $display("FAIL reset_tip: got %b want 0", tip_o); end
    vec_cnt++; if (recieve_data_o !== 1'b0) begin err_cnt++; $display("FAIL reset_rcv: got %b want 0", recieve_data_o); end
    PRESET = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic test_basic();
    int n, t, r; logic [NUM_SS-1:0] ln; logic re, te;
    drive(1, 0, 0, 2, 7, 1);
    pulse();
    observe(200, n, ln, t, r, re, te);
    vec_cnt++; if (n !== 16) begin err_cnt++; $display("FAIL basic_len: got %0d want 16", n); end
    vec_cnt++; if (ln !== 4'b1101) begin err_cnt++; $display("FAIL basic_line: got %b want 1101", ln); end
    vec_cnt++; if (t !== 16) begin err_cnt++; $display("FAIL basic_tip: got %0d want 16", t); end
    vec_cnt++; if (r !== 0) begin err_cnt++; $display("FAIL basic_early_rcv: got %0d want 0", r); end
    vec_cnt++; if (re !== 1'b1) begin err_cnt++; $display("FAIL basic_rcv: got %b want 1", re); end
    vec_cnt++; if (te !== 1'b0) begin err_cnt++; $display("FAIL basic_tip_end: got %b want 0", te); end
    @(negedge PCLK);
    vec_cnt++; if (recieve_data_o !== 1'b0) begin err_cnt++; $display("FAIL basic_rcv_width: got %b want 0", recieve_data_o); end
    idle_wait();
  endtask

  task automatic test_wait_mode();
    int n, t, r, e; logic [NUM_SS-1:0] ln; logic re, te;
    for (int w = 1; w >= 0; w--) begin
      drive(1, w[0], 1, 2, 7, 1);
      e = model_len(1, w[0], 1, 2, 7, 1);
      pulse();
      observe(200, n, ln, t, r, re, te);
      vec_cnt++; if (n !== e) begin err_cnt++; $display("FAIL wait_len spiswai=%0d: got %0d want %0d", w, n, e); end
      vec_cnt++; if (re !== (e > 0)) begin err_cnt++; $display("FAIL wait_rcv spiswai=%0d: got %b want %0d", w, re, e > 0); end
      idle_wait();
    end
  endtask

  task automatic test_abort(input bit use_reset);
    int bad;
    drive(1, 0, 0, 2, 7, 1);
    pulse();
    repeat (4) @(negedge PCLK);
    vec_cnt++; if (ss_o !== 4'b1101) begin err_cnt++; $display("FAIL abort_pre rst=%0d: got %b want 1101", use_reset, ss_o); end
    if (use_reset) PRESET = 1'b1; else mstr_i = 1'b0;
    @(negedge PCLK);
    vec_cnt++; if (ss_o !== ALL1) begin err_cnt++; $display("FAIL abort_ss rst=%0d: got %b want %b", use_reset, ss_o, ALL1); end
    vec_cnt++; if (tip_o !== 1'b0) begin err_cnt++; $display("FAIL abort_tip rst=%0d: got %b want 0", use_reset, tip_o); end
    vec_cnt++; if (recieve_data_o !== 1'b0) begin err_cnt++; $display("FAIL abort_rcv rst=%0d: got %b want 0", use_reset, recieve_data_o); end
    PRESET = 1'b0;
    mstr_i = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge PCLK);
      if (recieve_data_o !== 1'b0 || ss_o !== ALL1) bad++;
    end
    vec_cnt++; if (bad !== 0) begin err_cnt++; $display("FAIL abort_after rst=%0d: got %0d bad cycles want 0", use_reset, bad); end
  endtask

  task automatic test_div0();
    int n, t, r; logic [NUM_SS-1:0] ln; logic re, te;
    drive(1, 0, 0, 0, 7, 2);
    pulse();
    observe(200, n, ln, t, r, re, te);
    vec_cnt++; if (n !== 0) begin err_cnt++; $display("FAIL div0_len: got %0d want 0", n); end
    vec_cnt++; if (re !== 1'b0 || te !== 1'b0) begin err_cnt++; $display("FAIL div0_flags: got rcv=%b tip=%b want 0 0", re, te); end
    idle_wait();
  endtask

  task automatic test_sweep();
    int n, t, r; logic [NUM_SS-1:0] ln; logic re, te;
    for (int s = 0; s < NUM_SS; s++) begin
      for (int l = 0; l < 32; l++) begin
        drive(1, 0, 0, 1, l, s);
        pulse();
        observe(100, n, ln, t, r, re, te);
        vec_cnt++; if (n !== l + 1) begin err_cnt++; $display("FAIL sweep_len sel=%0d len=%0d: got %0d want %0d", s, l, n, l + 1); end
        vec_cnt++; if (ln !== model_line(s)) begin err_cnt++; $display("FAIL sweep_line sel=%0d len=%0d: got %b want %b", s, l, ln, model_line(s)); end
        vec_cnt++; if (re !== 1'b1) begin err_cnt++; $display("FAIL sweep_rcv sel=%0d len=%0d: got %b want 1", s, l, re); end
        repeat (GAP + GUARD_CYC) @(negedge PCLK);
      end
    end
  endtask

  task automatic test_midchange();
    int n, k;
    drive(1, 0, 0, 3, 4, 2);
    pulse();
    n = 0; k = 0;
    while (ss_o !== ALL1 && k < 200) begin
      k++;
      if (ss_o === 4'b1011 && tip_o === 1'b1) n++;
      BaudRateDivisor_i = BAUD_W'($urandom_range(0, 9));
      frame_len_i       = LEN_W'($urandom_range(0, 31));
      ss_sel_i          = SEL_W'($urandom_range(0, 3));
      @(negedge PCLK);
    end
    vec_cnt++; if (n !== 15 || k !== 15) begin err_cnt++; $display("FAIL midchange_len: got %0d/%0d want 15/15", n, k); end
    vec_cnt++; if (recieve_data_o !== 1'b1) begin err_cnt++; $display("FAIL midchange_rcv: got %b want 1", recieve_data_o); end
    idle_wait();
  endtask

  task automatic test_random();
    int n, t, r, e, m, w, md, dv, ln_i, sl;
    logic [NUM_SS-1:0] ln; logic re, te;
    for (int i = 0; i < 24; i++) begin
      m    = ($urandom_range(0, 3) != 0) ? 1 : 0;
      w    = $urandom_range(0, 1);
      md   = $urandom_range(0, 3);
      dv   = $urandom_range(0, 4);
      ln_i = $urandom_range(0, 31);
      sl   = $urandom_range(0, 3);
      drive(m[0], w[0], md, dv, ln_i, sl);
      e = model_len(m[0], w[0], md, dv, ln_i, sl);
      pulse();
      observe(300, n, ln, t, r, re, te);
      vec_cnt++; if (n !== e || t !== e) begin err_cnt++; $display("FAIL rand_len #%0d: got %0d tip %0d want %0d", i, n, t, e); end
      vec_cnt++; if (re !== (e > 0) || r !== 0) begin err_cnt++; $display("FAIL rand_rcv #%0d: got %b/%0d want %0d/0", i, re, r, e > 0); end
      if (e > 0) begin
        vec_cnt++; if (ln !== model_line(sl)) begin err_cnt++; $display("FAIL rand_line #%0d: got %b want %b", i, ln, model_line(sl)); end
      end
      idle_wait();
    end
    mstr_i = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [NUM_SS-1:0] tr[$];
    int lows[$], highs[$];
    logic [NUM_SS-1:0] cur;
    int n;
    drive(1, 0, 0, 1, 3, 0);
    @(negedge PCLK);
    send_data_i = 1'b1;
    repeat (60) begin
      @(negedge PCLK);
      tr.push_back(ss_o);
    end
    send_data_i = 1'b0;
    cur = tr[0];
    n = 1;
    for (int i = 1; i < tr.size(); i++) begin
      if (tr[i] === cur) n++;
      else begin
        if (cur === ALL1) highs.push_back(n); else lows.push_back(n);
        cur = tr[i];
        n = 1;
      end
    end
    vec_cnt++; if (tr[0] !== 4'b1110) begin err_cnt++; $display("FAIL b2b_line: got %b want 1110", tr[0]); end
    vec_cnt++; if (lows.size() < 3 || highs.size() < 2) begin err_cnt++; $display("FAIL b2b_frames: got %0d frames want >=3", lows.size()); end
    else begin
      for (int i = 0; i < 2; i++) begin
        vec_cnt++; if (lows[i] !== 4) begin err_cnt++; $display("FAIL b2b_low%0d: got %0d want 4", i, lows[i]); end
        vec_cnt++; if (highs[i] !== GAP) begin err_cnt++; $display("FAIL b2b_gap%0d: got %0d want %0d", i, highs[i], GAP); end
      end
    end
    idle_wait();
    idle_wait();
  endtask

  task automatic test_done_drop();
    int n, t, r, bad; logic [NUM_SS-1:0] ln; logic re, te;
    drive(1, 0, 0, 1, 1, 3);
    pulse();
    observe(100, n, ln, t, r, re, te);
    vec_cnt++; if (re !== 1'b1) begin err_cnt++; $display("FAIL drop_done: got rcv %b want 1", re); end
    send_data_i = 1'b1;
    @(negedge PCLK);
    send_data_i = 1'b0;
    bad = 0;
    repeat (GUARD_CYC + 6) begin
      @(negedge PCLK);
      if (ss_o !== ALL1) bad++;
    end
    vec_cnt++; if (bad !== 0) begin err_cnt++; $display("FAIL drop_in_done: got %0d low cycles want 0", bad); end
  endtask

`ifdef SPI_SS_GUARD_EN
  task automatic test_guard_pending();
    int n, t, r, k; logic [NUM_SS-1:0] ln; logic re, te;
    drive(1, 0, 0, 1, 2, 2);
    pulse();
    observe(100, n, ln, t, r, re, te);
    @(negedge PCLK);
    send_data_i = 1'b1;
    @(negedge PCLK);
    send_data_i = 1'b0;
    k = 0;
    while (ss_o === ALL1 && k < 20) begin
      @(negedge PCLK);
      k++;
    end
    vec_cnt++; if (k !== GUARD_CYC) begin err_cnt++; $display("FAIL guard_pend_start: got %0d want %0d", k, GUARD_CYC); end
    observe(100, n, ln, t, r, re, te);
    vec_cnt++; if (n !== 3 || ln !== 4'b1011) begin err_cnt++; $display("FAIL guard_pend_frame: got %0d %b want 3 1011", n, ln); end
    idle_wait();
    idle_wait();
  endtask
`endif

  task automatic test_long();
    int n, t, r; logic [NUM_SS-1:0] ln; logic re, te;
    drive(1, 0, 0, 2049, 31, 3);
    pulse();
    observe(70000, n, ln, t, r, re, te);
    vec_cnt++; if (n !== 65568) begin err_cnt++; $display("FAIL long_len: got %0d want 65568", n); end
    vec_cnt++; if (ln !== 4'b0111 || re !== 1'b1) begin err_cnt++; $display("FAIL long_line_rcv: got %b %b want 0111 1", ln, re); end
    idle_wait();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_mode();
    test_abort(1'b0);
    test_abort(1'b1);
    test_div0();
    test_sweep();
    test_midchange();
    test_random();
    test_back_to_back();
    test_done_drop();
`ifdef SPI_SS_GUARD_EN
    test_guard_pending();
`endif
    test_long();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
